// File: rtl/huff_stream_packer.sv
// Huffman back end: programmable code table and an MSB-first bit packer.
// It emits fixed-width words and flushes a tagged, zero-padded partial word at frame end.
module huff_stream_packer #(
   parameter int NUM_SYM      = 16,
   parameter int MAX_CODE_LEN = 16,
   parameter int OUT_W        = 32
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              tbl_we,
   input  logic [$clog2(NUM_SYM)-1:0]        tbl_addr,
   input  logic [MAX_CODE_LEN-1:0]           tbl_code,
   input  logic [$clog2(MAX_CODE_LEN+1)-1:0] tbl_len,
   input  logic                              sym_valid,
   output logic                              sym_ready,
   input  logic [$clog2(NUM_SYM)-1:0]        sym_data,
   input  logic                              sym_last,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [OUT_W-1:0]                  out_data,
   output logic [$clog2(OUT_W+1)-1:0]        out_bits,
   output logic                              out_last,
   output logic                              err_zero_len,
   input  logic                              err_clr
);

   localparam int SYM_W  = $clog2(NUM_SYM);
   localparam int LEN_W  = $clog2(MAX_CODE_LEN+1);
   localparam int BITS_W = $clog2(OUT_W+1);
   localparam int ACC_W  = OUT_W + MAX_CODE_LEN;
   localparam int FILL_W = $clog2(ACC_W+1);

   localparam logic [FILL_W-1:0] ACC_F = FILL_W'(ACC_W);
   localparam logic [FILL_W-1:0] OUT_F = FILL_W'(OUT_W);
   localparam logic [BITS_W-1:0] OUT_B = BITS_W'(OUT_W);

   typedef enum logic {RUN, FLUSH} state_t;

   logic [MAX_CODE_LEN-1:0] code_mem [NUM_SYM];
   logic [LEN_W-1:0]        len_mem  [NUM_SYM];

   state_t             state;
   logic [ACC_W-1:0]   acc;
   logic [FILL_W-1:0]  fill;

   logic [MAX_CODE_LEN-1:0] cur_code;
   logic [LEN_W-1:0]        cur_len;
   logic [FILL_W-1:0]       sh;
   logic [ACC_W-1:0]        aligned;
   logic [ACC_W-1:0]        ins;
   logic                    sym_hs;
   logic                    out_hs;

   assign cur_code = code_mem[sym_data];
   assign cur_len  = len_mem[sym_data];

   // Left-justify the code (dropping bits above its length), then slot it under the fill.
   assign sh      = ACC_F - FILL_W'(cur_len);
   assign aligned = {{OUT_W{1'b0}}, cur_code} << sh;
   assign ins     = aligned >> fill;

   assign sym_ready = (state == RUN) && (fill < OUT_F);
   assign out_valid = (state == FLUSH) || (fill >= OUT_F);
   assign out_data  = acc[ACC_W-1 -: OUT_W];
   assign out_last  = (state == FLUSH) && (fill <= OUT_F);

   always_comb begin
      out_bits = '0;
      if (out_valid)
         out_bits = (fill < OUT_F) ? BITS_W'(fill) : OUT_B;
   end

   assign sym_hs = sym_valid && sym_ready;
   assign out_hs = out_valid && out_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_SYM; i++) begin
            code_mem[i] <= '0;
            len_mem[i]  <= '0;
         end
      end else if (tbl_we) begin
         code_mem[tbl_addr] <= tbl_code;
         len_mem[tbl_addr]  <= tbl_len;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= RUN;
         acc   <= '0;
         fill  <= '0;
      end else begin
         unique case (state)
            RUN: begin
               if (sym_hs) begin
                  acc  <= acc | ins;
                  fill <= fill + FILL_W'(cur_len);
                  if (sym_last)
                     state <= FLUSH;
               end else if (out_hs) begin
                  acc  <= acc << OUT_W;
                  fill <= fill - OUT_F;
               end
            end
            FLUSH: begin
               if (out_ready) begin
                  if (out_last) begin
                     acc   <= '0;
                     fill  <= '0;
                     state <= RUN;
                  end else begin
                     acc  <= acc << OUT_W;
                     fill <= fill - OUT_F;
                  end
               end
            end
            default: state <= RUN;
         endcase
      end
   end

   // A zero-length hit wins over a same-cycle clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         err_zero_len <= 1'b0;
      else if (sym_hs && (cur_len == '0))
         err_zero_len <= 1'b1;
      else if (err_clr)
         err_zero_len <= 1'b0;
   end

endmodule

// File: tb/tb_huff_stream_packer.sv
// Directed bench for huff_stream_packer with a bit-level scoreboard model.
// Expected words are queued on symbol acceptance and popped on output handshakes.
module tb_huff_stream_packer;

   localparam int NS = 4;
   localparam int ML = 8;
   localparam int OW = 8;

   logic       clk = 0;
   logic       reset = 0;
   logic       tbl_we = 0;
   logic [1:0] tbl_addr = 0;
   logic [7:0] tbl_code = 0;
   logic [3:0] tbl_len = 0;
   logic       sym_valid = 0;
   logic       sym_ready;
   logic [1:0] sym_data = 0;
   logic       sym_last = 0;
   logic       out_valid;
   logic       out_ready = 1;
   logic [7:0] out_data;
   logic [3:0] out_bits;
   logic       out_last;
   logic       err_zero_len;
   logic       err_clr = 0;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] data;
      logic [3:0] bits;
      logic       last;
   } word_t;

   word_t q[$];
   bit    mbits[$];
   logic [7:0] tcode [NS];
   logic [3:0] tlen  [NS];

   huff_stream_packer #(.NUM_SYM(NS), .MAX_CODE_LEN(ML), .OUT_W(OW)) dut (
      .clk(clk), .reset(reset),
      .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_code(tbl_code), .tbl_len(tbl_len),
      .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_data(sym_data), .sym_last(sym_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_bits(out_bits), .out_last(out_last),
      .err_zero_len(err_zero_len), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic emit(input int n, input bit l);
      word_t w;
      w.data = '0;
      for (int i = 0; i < n; i++) w.data[7-i] = mbits.pop_front();
      w.bits = 4'(n);
      w.last = l;
      q.push_back(w);
   endtask

   task automatic model_accept(input int s, input bit l);
      for (int i = int'(tlen[s]) - 1; i >= 0; i--) mbits.push_back(tcode[s][i]);
      if (l) begin
         while (mbits.size() > 8) emit(8, 0);
         emit(mbits.size(), 1);
      end else begin
         while (mbits.size() >= 8) emit(8, 0);
      end
   endtask

   always @(negedge clk) begin
      if (reset && out_valid && out_ready) begin
         word_t w;
         checks++;
         assert (q.size() > 0) else begin
            errors++;
            $error("FAIL unexpected_word: observed %0h expected none", out_data);
         end
         if (q.size() > 0) begin
            w = q.pop_front();
            chk("word_data", 32'(out_data), 32'(w.data));
            chk("word_bits", 32'(out_bits), 32'(w.bits));
            chk("word_last", 32'(out_last), 32'(w.last));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int a, input logic [7:0] c, input logic [3:0] l);
      tbl_we = 1; tbl_addr = 2'(a); tbl_code = c; tbl_len = l;
      tick();
      tcode[a] = c; tlen[a] = l;
      tbl_we = 0;
   endtask

   task automatic send(input int s, input bit l);
      bit ok = 0;
      sym_valid = 1; sym_data = 2'(s); sym_last = l;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (sym_ready) begin ok = 1; break; end
      end
      if (ok) begin
         @(posedge clk);
         model_accept(s, l);
         #1;
      end
      checks++;
      assert (ok) else begin
         errors++;
         $error("FAIL send_timeout: observed ready=0 expected ready=1");
      end
      sym_valid = 0; sym_last = 0;
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && q.size() > 0; i++) @(negedge clk);
      @(negedge clk);
      chk("drain_empty", 32'(q.size()), 32'd0);
      chk("drain_idle", 32'(out_valid), 32'd0);
      tick();
   endtask

   initial begin
      for (int i = 0; i < NS; i++) begin tcode[i] = 0; tlen[i] = 0; end
      #12;
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_bits", 32'(out_bits), 32'd0);
      chk("rst_out_last", 32'(out_last), 32'd0);
      chk("rst_err", 32'(err_zero_len), 32'd0);
      reset = 1;
      tick();
      chk("rst_sym_ready", 32'(sym_ready), 32'd1);

      wr(0, 8'b0, 4'd1);
      wr(1, 8'b10, 4'd2);
      wr(2, 8'b110, 4'd3);
      wr(3, 8'b111, 4'd3);

      // Frame A: 1,0,2 -> 10011000 / 6 bits
      send(1, 0); send(0, 0); send(2, 1);
      @(negedge clk);
      chk("a_flush_ready", 32'(sym_ready), 32'd0);
      chk("a_data", 32'(out_data), 32'b10011000);
      chk("a_bits", 32'(out_bits), 32'd6);
      drain();

      // Frame B: 3,3,3 -> two words
      send(3, 0); send(3, 0); send(3, 1);
      drain();

      // Frame C: exactly one full word, no trailing empty word
      send(0, 0); send(0, 0); send(0, 0); send(0, 0); send(1, 0); send(1, 1);
      @(negedge clk);
      chk("c_data", 32'(out_data), 32'b00001010);
      chk("c_last", 32'(out_last), 32'd1);
      drain();

      // Backpressure
      out_ready = 0;
      send(3, 0); send(3, 0); send(3, 0);
      repeat (5) begin
         @(negedge clk);
         chk("bp_valid", 32'(out_valid), 32'd1);
         chk("bp_data", 32'(out_data), 32'hFF);
         chk("bp_ready", 32'(sym_ready), 32'd0);
      end
      tick();
      out_ready = 1;
      send(3, 0); send(3, 0); send(3, 0); send(3, 1);
      drain();

      // Zero-length entry
      wr(2, 8'b110, 4'd0);
      send(2, 1);
      @(negedge clk);
      chk("z_err", 32'(err_zero_len), 32'd1);
      chk("z_bits", 32'(out_bits), 32'd0);
      drain();
      err_clr = 1;
      tick();
      err_clr = 0;
      chk("z_err_clr", 32'(err_zero_len), 32'd0);

      // Reset mid-frame with fill = 5
      send(2, 0); send(1, 0); send(0, 0); send(1, 0);
      @(negedge clk);
      chk("m_err_pre", 32'(err_zero_len), 32'd1);
      reset = 0;
      q.delete(); mbits.delete();
      for (int i = 0; i < NS; i++) begin tcode[i] = 0; tlen[i] = 0; end
      #1;
      chk("m_valid", 32'(out_valid), 32'd0);
      chk("m_err", 32'(err_zero_len), 32'd0);
      chk("m_bits", 32'(out_bits), 32'd0);
      tick();
      reset = 1;
      tick();
      chk("m_ready", 32'(sym_ready), 32'd1);
      send(1, 1);
      @(negedge clk);
      chk("m_err_post", 32'(err_zero_len), 32'd1);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/huff_stream_packer.md
Name: huff_stream_packer

Overview:
- Parametrised streaming back end for the Huffman encoder. It holds a programmable code table of (code, length) per symbol.
- It accepts a stream of symbols with valid/ready and emits MSB-first packed codeword bits as fixed-width words with valid/ready.
- On frame end it flushes a zero-padded partial word tagged with its valid-bit count.
- It sits between the code-table generator (encoder tree stage) and the bitstream writer.

Parameters:
- NUM_SYM, 16, number of table entries; SYM_W = $clog2(NUM_SYM) (derived localparam).
- MAX_CODE_LEN, 16, maximum codeword length in bits; must be <= OUT_W.
- OUT_W, 32, output word width in bits; accumulator width ACC_W = OUT_W + MAX_CODE_LEN.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- tbl_we  in  1  table write strobe.
- tbl_addr  in  SYM_W  table entry written.
- tbl_code  in  MAX_CODE_LEN  codeword, right-aligned (LSBs); MSB of the code is at bit tbl_len-1.
- tbl_len  in  $clog2(MAX_CODE_LEN+1)  code length; 0 = invalid entry.
- sym_valid  in  1  symbol present.
- sym_ready  out  1  packer can accept a symbol.
- sym_data  in  SYM_W  symbol index.
- sym_last  in  1  final symbol of the frame.
- out_valid  out  1  output word present.
- out_ready  in  1  sink accepts the word.
- out_data  out  OUT_W  packed bits, first bit in the MSB.
- out_bits  out  $clog2(OUT_W+1)  valid bits in out_data (OUT_W except the final partial word).
- out_last  out  1  final word of the frame.
- err_zero_len  out  1  sticky: a symbol with table length 0 was accepted.
- err_clr  in  1  synchronous clear of err_zero_len.

Behaviour:
- Reset (async, reset=0):
  - All table entries become code 0, len 0.
  - Accumulator cleared, fill = 0, state RUN.
  - out_valid=0, out_data=0, out_bits=0, out_last=0, err_zero_len=0, sym_ready=1 once reset is released.
  - Reset mid-frame discards all buffered bits and returns to this state.
- Table:
  - Register array, written on a rising edge when tbl_we=1.
  - A write is visible to symbols accepted on the following cycle. A same-cycle write and lookup of the same address uses the old entry.
  - Writes are legal in any state.
- States: RUN, FLUSH.
  - RUN: sym_ready = (fill < OUT_W).
    - On a sym_valid & sym_ready edge, with L = table len of sym_data:
      - The code's L bits are appended below the existing fill bits (MSB-first) and fill += L.
      - If L = 0: no bits are appended and err_zero_len is set.
    - If sym_last is accepted, go to FLUSH next cycle.
  - RUN output: out_valid = (fill >= OUT_W), out_data = top OUT_W accumulator bits, out_bits = OUT_W, out_last = 0.
    - On out handshake: accumulator shifts left by OUT_W, fill -= OUT_W.
  - Simultaneous in/out in RUN is impossible: ready requires fill < OUT_W, valid requires fill >= OUT_W.
  - FLUSH: sym_ready = 0.
    - out_valid = 1.
    - out_bits = min(fill, OUT_W); unused LSBs of out_data are zero.
    - out_last = (fill <= OUT_W).
    - On handshake: shift and decrement as in RUN. If out_last was 1, set fill = 0, clear the accumulator and return to RUN.
    - If FLUSH is entered with fill = 0 (last symbol had len 0 and nothing was buffered), one word with out_bits=0, out_data=0, out_last=1 is emitted.
- Outputs are registered / derived from registers only. out_data, out_bits and out_last are held stable while out_valid=1 and out_ready=0.
- Latency: a symbol accepted at edge N is reflected in fill at N. A word completed at N is presented as out_valid in the cycle after N.
- err_zero_len: set has priority over a same-cycle err_clr.
- Throughput: one symbol per cycle while fill < OUT_W.

Test Plan (NUM_SYM=4, MAX_CODE_LEN=8, OUT_W=8; table s0="0"/1, s1="10"/2, s2="110"/3, s3="111"/3):
- Symbols 1,0,2 (last on 2), out_ready=1 -> one word: out_data=8'b10011000, out_bits=6, out_last=1; sym_ready low during FLUSH.
- Symbols 3,3,3 (last) -> word 8'b11111111, out_bits=8, out_last=0; then 8'b10000000, out_bits=1, out_last=1.
- Symbols 0,0,0,0,1,1 (last; exactly 8 bits) -> a single word 8'b00001010, out_bits=8, out_last=1, with no extra empty word.
- Backpressure: hold out_ready=0 and stream s3 continuously -> sym_ready=0 once fill>=8; out_data stays 8'b11111111 for 5 cycles; after out_ready=1 the stream resumes with no bit loss.
- Zero-length entry: write s2 len=0, send 2 (last) with fill=0 -> err_zero_len=1, one word with out_bits=0, out_last=1. err_clr=1 clears the flag the next cycle.
- Reset mid-frame: drop reset with fill=5 -> out_valid=0, err_zero_len=0, all table lengths 0, sym_ready=1 after release; sending s1 then raises err_zero_len.
